// File: rtl/atmega_tim_icp_pkg.sv
// Shared definitions for the 16-bit input-capture timer.
// Holds the default register addresses, the register bit positions and the clock-select encodings.
// The clock-select encodings match the ones the 8-bit timers use.
package atmega_tim_icp_pkg;

  localparam int BUS_ADDR_IO_LEN   = 6;
  localparam int BUS_ADDR_DATA_LEN = 8;

  localparam logic [BUS_ADDR_DATA_LEN-1:0] TCCR_ADDR_DEF  = 8'h81;
  localparam logic [BUS_ADDR_DATA_LEN-1:0] TCNTL_ADDR_DEF = 8'h84;
  localparam logic [BUS_ADDR_DATA_LEN-1:0] TCNTH_ADDR_DEF = 8'h85;
  localparam logic [BUS_ADDR_DATA_LEN-1:0] ICRL_ADDR_DEF  = 8'h86;
  localparam logic [BUS_ADDR_DATA_LEN-1:0] ICRH_ADDR_DEF  = 8'h87;
  localparam logic [BUS_ADDR_DATA_LEN-1:0] TIMSK_ADDR_DEF = 8'h6F;
  localparam logic [BUS_ADDR_IO_LEN-1:0]   TIFR_ADDR_DEF  = 6'h16;

  // TCCR fields
  localparam int CS_LSB   = 0;
  localparam int CS_MSB   = 2;
  localparam int ICES_BIT = 6;
  localparam int ICNC_BIT = 7;
  // TIFR / TIMSK fields
  localparam int TOV_BIT  = 0;
  localparam int ICF_BIT  = 5;
  localparam int TOIE_BIT = 0;
  localparam int ICIE_BIT = 5;

  typedef enum logic [2:0] {
    CS_STOP    = 3'd0,
    CS_CLK     = 3'd1,
    CS_CLK8    = 3'd2,
    CS_CLK64   = 3'd3,
    CS_CLK256  = 3'd4,
    CS_CLK1024 = 3'd5,
    CS_STOP6   = 3'd6,
    CS_STOP7   = 3'd7
  } cs_t;

  // An IO-space register is also visible in data space 'h20 higher.
  function automatic logic [BUS_ADDR_DATA_LEN-1:0] io_alias(input logic [BUS_ADDR_IO_LEN-1:0] a);
    logic [BUS_ADDR_DATA_LEN-1:0] r;
    r = '0;
    r[BUS_ADDR_IO_LEN-1:0] = a;
    return r + 8'h20;
  endfunction

endpackage

// File: rtl/atmega_tim_icp_if.sv
// IO-space and data-space register bus shared by the timers.
// Single-cycle accesses: a write is committed on the clock edge, and read data is combinational.
// No backpressure; every access completes in the cycle it is presented.
interface atmega_tim_icp_if;
  import atmega_tim_icp_pkg::*;

  logic [BUS_ADDR_IO_LEN-1:0]   addr_io;
  logic                         wr_io;
  logic                         rd_io;
  logic [7:0]                   bus_io_in;
  logic [7:0]                   bus_io_out;

  logic [BUS_ADDR_DATA_LEN-1:0] addr_dat;
  logic                         wr_dat;
  logic                         rd_dat;
  logic [7:0]                   bus_dat_in;
  logic [7:0]                   bus_dat_out;

  modport master (
    output addr_io, wr_io, rd_io, bus_io_in, addr_dat, wr_dat, rd_dat, bus_dat_in,
    input  bus_io_out, bus_dat_out
  );

  modport slave (
    input  addr_io, wr_io, rd_io, bus_io_in, addr_dat, wr_dat, rd_dat, bus_dat_in,
    output bus_io_out, bus_dat_out
  );
endinterface

// File: rtl/atmega_icp_filter.sv
// Capture-pin conditioning: a 2-flop synchronizer, an optional 4-sample noise canceller, and an edge detector.
// The capture strobe is asserted 2 cycles after the first sample with the canceller off, and 5 cycles after it with the canceller on.
// No backpressure; the strobe lasts exactly one cycle.
module atmega_icp_filter (
  input  logic clk,
  input  logic rst,
  input  logic icp,
  input  logic icnc,
  input  logic ices,
  output logic capture
);

  logic       sync1, sync2;
  logic       filt, filt_d;
  logic [1:0] cnt;

  // Bring the asynchronous pin into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= icp;
      sync2 <= sync1;
    end
  end

  // Filtered level: follows sync2 directly, or only after 4 consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= 1'b0;
      cnt  <= '0;
    end else if (!icnc) begin
      filt <= sync2;
      cnt  <= '0;
    end else if (sync2 == filt) begin
      cnt  <= '0;
    end else if (cnt == 2'd3) begin
      filt <= sync2;
      cnt  <= '0;
    end else begin
      cnt  <= cnt + 2'd1;
    end
  end

  // Delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) filt_d <= 1'b0;
    else     filt_d <= filt;
  end

  // Only a change of the filtered level can fire, so toggling ICES or ICNC alone never captures
  always_comb begin
    capture = ices ? (filt & ~filt_d) : (~filt & filt_d);
  end

endmodule

// File: rtl/atmega_tim_icp.sv
// 16-bit timer with input capture, an overflow flag, TEMP-latched 16-bit register access, and interrupt requests.
// A capture updates ICR/ICF 3 cycles after the pin is first sampled, or 6 cycles with the canceller enabled; register reads are combinational.
// No backpressure; bus accesses complete in a single cycle.
module atmega_tim_icp
  import atmega_tim_icp_pkg::*;
#(
  parameter logic [BUS_ADDR_DATA_LEN-1:0] TCCR_ADDR  = TCCR_ADDR_DEF,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] TCNTL_ADDR = TCNTL_ADDR_DEF,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] TCNTH_ADDR = TCNTH_ADDR_DEF,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] ICRL_ADDR  = ICRL_ADDR_DEF,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] ICRH_ADDR  = ICRH_ADDR_DEF,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] TIMSK_ADDR = TIMSK_ADDR_DEF,
  parameter logic [BUS_ADDR_IO_LEN-1:0]   TIFR_ADDR  = TIFR_ADDR_DEF
) (
  input  logic              rst,
  input  logic              clk,
  input  logic              clk8,
  input  logic              clk64,
  input  logic              clk256,
  input  logic              clk1024,
  atmega_tim_icp_if.slave   bus,
  input  logic              icp,
  output logic              tov_int,
  input  logic              tov_int_rst,
  output logic              icf_int,
  input  logic              icf_int_rst
);

  localparam logic [BUS_ADDR_DATA_LEN-1:0] TIFR_DAT_ADDR = io_alias(TIFR_ADDR);

  logic [7:0]  tccr, timsk, temp, tifr_val, tifr_clr;
  logic [15:0] tcnt, icr;
  logic        tov, icf;
  logic [3:0]  pclk_d;
  logic        tick, ovf, capture;
  logic        wr_tccr, wr_tcntl, wr_tcnth, wr_timsk, rd_tcntl, rd_icrl;
  cs_t         cs;

  atmega_icp_filter u_filter (
    .clk     (clk),
    .rst     (rst),
    .icp     (icp),
    .icnc    (tccr[ICNC_BIT]),
    .ices    (tccr[ICES_BIT]),
    .capture (capture)
  );

  // Bus write/read decode and the write-one-to-clear mask for TIFR
  always_comb begin
    wr_tccr  = bus.wr_dat && (bus.addr_dat == TCCR_ADDR);
    wr_tcntl = bus.wr_dat && (bus.addr_dat == TCNTL_ADDR);
    wr_tcnth = bus.wr_dat && (bus.addr_dat == TCNTH_ADDR);
    wr_timsk = bus.wr_dat && (bus.addr_dat == TIMSK_ADDR);
    rd_tcntl = bus.rd_dat && (bus.addr_dat == TCNTL_ADDR);
    rd_icrl  = bus.rd_dat && (bus.addr_dat == ICRL_ADDR);
    tifr_clr = '0;
    if (bus.wr_io && (bus.addr_io == TIFR_ADDR))      tifr_clr = tifr_clr | bus.bus_io_in;
    if (bus.wr_dat && (bus.addr_dat == TIFR_DAT_ADDR)) tifr_clr = tifr_clr | bus.bus_dat_in;
  end

  // Registered copies of the prescaler clocks for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) pclk_d <= '0;
    else     pclk_d <= {clk1024, clk256, clk64, clk8};
  end

  // Count tick from the clock select
  always_comb begin
    cs   = cs_t'(tccr[CS_MSB:CS_LSB]);
    tick = 1'b0;
    case (cs)
      CS_CLK:     tick = 1'b1;
      CS_CLK8:    tick = clk8    & ~pclk_d[0];
      CS_CLK64:   tick = clk64   & ~pclk_d[1];
      CS_CLK256:  tick = clk256  & ~pclk_d[2];
      CS_CLK1024: tick = clk1024 & ~pclk_d[3];
      default:    tick = 1'b0;
    endcase
    // A TCNTL write overrides both the increment and the wrap
    ovf = tick && !wr_tcntl && (tcnt == 16'hFFFF);
  end

  // Control and mask registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tccr  <= '0;
      timsk <= '0;
    end else begin
      if (wr_tccr)  tccr  <= bus.bus_dat_in;
      if (wr_timsk) timsk <= bus.bus_dat_in;
    end
  end

  // Counter: a software load has priority over the increment
  always_ff @(posedge clk) begin
    if (rst)           tcnt <= '0;
    else if (wr_tcntl) tcnt <= {temp, bus.bus_dat_in};
    else if (tick)     tcnt <= tcnt + 16'd1;
  end

  // TEMP: loaded by a high-byte write, or latched from the high byte when a low byte is read
  always_ff @(posedge clk) begin
    if (rst)           temp <= '0;
    else if (wr_tcnth) temp <= bus.bus_dat_in;
    else if (rd_tcntl) temp <= tcnt[15:8];
    else if (rd_icrl)  temp <= icr[15:8];
  end

  // Capture register snapshots the pre-increment count
  always_ff @(posedge clk) begin
    if (rst)          icr <= '0;
    else if (capture) icr <= tcnt;
  end

  // Flags: a hardware set wins over a software clear or a vector acknowledge
  always_ff @(posedge clk) begin
    if (rst) begin
      tov <= 1'b0;
      icf <= 1'b0;
    end else begin
      if (ovf)                                 tov <= 1'b1;
      else if (tifr_clr[TOV_BIT] || tov_int_rst) tov <= 1'b0;
      if (capture)                             icf <= 1'b1;
      else if (tifr_clr[ICF_BIT] || icf_int_rst) icf <= 1'b0;
    end
  end

  // Interrupt requests and combinational register readback
  always_comb begin
    tifr_val          = '0;
    tifr_val[TOV_BIT] = tov;
    tifr_val[ICF_BIT] = icf;
    tov_int = !rst && tov && timsk[TOIE_BIT];
    icf_int = !rst && icf && timsk[ICIE_BIT];

    bus.bus_io_out = '0;
    if (bus.rd_io && !rst && (bus.addr_io == TIFR_ADDR)) bus.bus_io_out = tifr_val;

    bus.bus_dat_out = '0;
    if (bus.rd_dat && !rst) begin
      case (bus.addr_dat)
        TCCR_ADDR:     bus.bus_dat_out = tccr;
        TCNTL_ADDR:    bus.bus_dat_out = tcnt[7:0];
        TCNTH_ADDR:    bus.bus_dat_out = temp;
        ICRL_ADDR:     bus.bus_dat_out = icr[7:0];
        ICRH_ADDR:     bus.bus_dat_out = temp;
        TIMSK_ADDR:    bus.bus_dat_out = timsk;
        TIFR_DAT_ADDR: bus.bus_dat_out = tifr_val;
        default:       bus.bus_dat_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_atmega_tim_icp.sv
// Directed testbench for atmega_tim_icp with a queue-based scoreboard.
// Stimulus pushes hand-computed expectations into the scoreboard; a negedge monitor pops one entry and compares it whenever an observation is flagged.
// Inputs change 1 ns after posedge; outputs are sampled at negedge.
module tb_atmega_tim_icp;

  logic clk = 1'b0;
  logic rst;
  logic clk8, clk64, clk256, clk1024;
  logic icp, tov_int_rst, icf_int_rst;
  logic tov_int, icf_int;

  atmega_tim_icp_if bus();

  atmega_tim_icp dut (
    .rst         (rst),
    .clk         (clk),
    .clk8        (clk8),
    .clk64       (clk64),
    .clk256      (clk256),
    .clk1024     (clk1024),
    .bus         (bus),
    .icp         (icp),
    .tov_int     (tov_int),
    .tov_int_rst (tov_int_rst),
    .icf_int     (icf_int),
    .icf_int_rst (icf_int_rst)
  );

  always #5 clk = ~clk;

  // Scoreboard: kind 0 = data read, 1 = IO read, 2 = tov_int, 3 = icf_int
  int         kind_q[$];
  logic [7:0] exp_q[$];
  string      name_q[$];
  logic       obs_vld = 1'b0;
  int         total = 0;
  int         bad = 0;

  int         m_kind;
  logic [7:0] m_exp, m_act;
  string      m_name;

  always @(negedge clk) begin
    if (obs_vld) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty: observation with no expected value");
      end else begin
        m_kind = kind_q.pop_front();
        m_exp  = exp_q.pop_front();
        m_name = name_q.pop_front();
        case (m_kind)
          0:       m_act = bus.bus_dat_out;
          1:       m_act = bus.bus_io_out;
          2:       m_act = {7'b0, tov_int};
          default: m_act = {7'b0, icf_int};
        endcase
        total++;
        if (m_act !== m_exp) begin
          bad++;
          $display("FAIL %s: got %02h expected %02h", m_name, m_act, m_exp);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    bus.wr_dat  = 1'b0;
    bus.rd_dat  = 1'b0;
    bus.wr_io   = 1'b0;
    bus.rd_io   = 1'b0;
    tov_int_rst = 1'b0;
    icf_int_rst = 1'b0;
    obs_vld     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic push_exp(input int k, input logic [7:0] e, input string n);
    kind_q.push_back(k);
    exp_q.push_back(e);
    name_q.push_back(n);
    obs_vld = 1'b1;
  endtask

  task automatic wr_d(input logic [7:0] a, input logic [7:0] d);
    bus.addr_dat   = a;
    bus.bus_dat_in = d;
    bus.wr_dat     = 1'b1;
    cyc();
  endtask

  task automatic wr_i(input logic [5:0] a, input logic [7:0] d);
    bus.addr_io   = a;
    bus.bus_io_in = d;
    bus.wr_io     = 1'b1;
    cyc();
  endtask

  task automatic rd_d(input logic [7:0] a, input logic [7:0] e, input string n);
    bus.addr_dat = a;
    bus.rd_dat   = 1'b1;
    push_exp(0, e, n);
    cyc();
  endtask

  task automatic rd_i(input logic [5:0] a, input logic [7:0] e, input string n);
    bus.addr_io = a;
    bus.rd_io   = 1'b1;
    push_exp(1, e, n);
    cyc();
  endtask

  task automatic chk_int(input int k, input logic e, input string n);
    push_exp(k, {7'b0, e}, n);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    clk8 = 1'b0; clk64 = 1'b0; clk256 = 1'b0; clk1024 = 1'b0;
    icp = 1'b0; tov_int_rst = 1'b0; icf_int_rst = 1'b0;
    bus.addr_io = '0; bus.wr_io = 1'b0; bus.rd_io = 1'b0; bus.bus_io_in = '0;
    bus.addr_dat = '0; bus.wr_dat = 1'b0; bus.rd_dat = 1'b0; bus.bus_dat_in = '0;
    idle(2);

    // Reset state
    rd_d(8'h81, 8'h00, "rst_bus_zero_init");
    rst = 1'b0;
    rd_d(8'h81, 8'h00, "reset_tccr");
    rd_i(6'h16, 8'h00, "reset_tifr");
    rd_d(8'h84, 8'h00, "reset_tcnt_lo");
    chk_int(2, 1'b0, "reset_tov_int");
    chk_int(3, 1'b0, "reset_icf_int");

    // Rising-edge capture, no canceller: TCNT=1234 at W, pin first sampled at W+1, capture at W+4 -> 1237
    wr_d(8'h6F, 8'h20);
    wr_d(8'h81, 8'h41);
    wr_d(8'h85, 8'h12);
    wr_d(8'h84, 8'h34);
    icp = 1'b1;
    cyc();
    idle(3);
    chk_int(3, 1'b1, "icf_int_on_capture");
    rd_d(8'h86, 8'h37, "icr_lo_ices1");
    rd_d(8'h87, 8'h12, "icr_hi_ices1");
    rd_i(6'h16, 8'h20, "tifr_icf");
    wr_d(8'h6F, 8'h00);
    chk_int(3, 1'b0, "icf_int_masked");
    wr_i(6'h16, 8'h20);
    rd_i(6'h16, 8'h00, "tifr_icf_cleared");

    // Canceller on, rising edge: a fall is not captured and a 3-cycle glitch is rejected
    wr_d(8'h81, 8'hC1);
    icp = 1'b0;
    idle(10);
    rd_i(6'h16, 8'h00, "no_cap_fall_ices1");
    icp = 1'b1;
    idle(3);
    icp = 1'b0;
    idle(10);
    rd_i(6'h16, 8'h00, "glitch_3cyc_rejected");

    // A 4-cycle pulse captures 6 cycles after the first sample; ICR = TCNT = 6
    wr_d(8'h85, 8'h00);
    wr_d(8'h84, 8'h00);
    icp = 1'b1;
    cyc();
    idle(3);
    icp = 1'b0;
    idle(2);
    rd_i(6'h16, 8'h00, "icnc_pre_capture_read");
    rd_i(6'h16, 8'h20, "icnc_after_6cyc");
    rd_d(8'h86, 8'h06, "icr_lo_icnc");
    rd_d(8'h87, 8'h00, "icr_hi_icnc");

    // Acknowledge clears ICF; ICES=0 captures on the fall, and an ICES change alone does nothing
    idle(8);
    icf_int_rst = 1'b1;
    cyc();
    rd_i(6'h16, 8'h00, "icf_ack_clears");
    wr_d(8'h81, 8'h81);
    idle(2);
    rd_i(6'h16, 8'h00, "ices_change_no_cap");
    icp = 1'b1;
    idle(10);
    rd_i(6'h16, 8'h00, "rise_ignored_ices0");
    wr_d(8'h85, 8'h01);
    wr_d(8'h84, 8'h00);
    icp = 1'b0;
    cyc();
    idle(6);
    rd_d(8'h86, 8'h06, "icr_lo_fall");
    rd_d(8'h87, 8'h01, "icr_hi_fall");

    // Overflow: FFFE at W -> FFFF at W+1 -> 0000 and TOV at W+2
    wr_i(6'h16, 8'h20);
    wr_d(8'h6F, 8'h01);
    wr_d(8'h81, 8'h01);
    wr_d(8'h85, 8'hFF);
    wr_d(8'h84, 8'hFE);
    chk_int(2, 1'b0, "tov_int_pre");
    rd_i(6'h16, 8'h00, "tov_pre_wrap");
    rd_d(8'h84, 8'h00, "tcnt_after_wrap");
    rd_i(6'h16, 8'h01, "tov_set");
    chk_int(2, 1'b1, "tov_int_set");
    wr_i(6'h16, 8'h01);
    rd_i(6'h16, 8'h00, "tov_sw_clear");

    // A TCNTL write at FFFF suppresses that cycle's wrap
    wr_d(8'h85, 8'hFF);
    wr_d(8'h84, 8'hFF);
    wr_d(8'h84, 8'hFF);
    rd_i(6'h16, 8'h00, "wr_beats_ovf");
    wr_i(6'h16, 8'h01);

    // A software clear in the same cycle as the wrap loses to the set
    wr_d(8'h85, 8'hFF);
    wr_d(8'h84, 8'hFE);
    cyc();
    wr_i(6'h16, 8'h01);
    rd_i(6'h16, 8'h01, "set_beats_clear");
    tov_int_rst = 1'b1;
    cyc();
    rd_i(6'h16, 8'h00, "tov_ack_clears");

    // 16-bit access through TEMP; a capture with the counter stopped; the latched high byte survives the capture
    wr_d(8'h81, 8'h00);
    wr_d(8'h85, 8'hAB);
    wr_d(8'h84, 8'hCD);
    rd_d(8'h84, 8'hCD, "tcnt_lo_rd");
    rd_d(8'h85, 8'hAB, "tcnt_hi_rd");
    rd_d(8'h86, 8'h06, "icr_lo_latch");
    icp = 1'b1;
    idle(5);
    icp = 1'b0;
    idle(5);
    rd_d(8'h87, 8'h01, "icr_hi_temp_held");
    rd_i(6'h16, 8'h20, "cap_with_cs0");
    rd_d(8'h86, 8'hCD, "icr_lo_cs0");
    rd_d(8'h87, 8'hAB, "icr_hi_cs0");
    rd_d(8'h84, 8'hCD, "tcnt_frozen");

    // CS=3: exactly one tick per clk64 rising edge; clk8 toggles are ignored
    wr_i(6'h16, 8'h20);
    wr_d(8'h81, 8'h03);
    wr_d(8'h85, 8'h00);
    wr_d(8'h84, 8'h10);
    for (int i = 0; i < 4; i++) begin
      clk64 = 1'b1;
      clk8  = ~clk8;
      idle(3);
      clk64 = 1'b0;
      clk8  = ~clk8;
      idle(5);
    end
    rd_d(8'h84, 8'h14, "cs64_count");

    // Reset one cycle after a pending edge discards it
    wr_d(8'h81, 8'h01);
    wr_d(8'h6F, 8'h21);
    icp = 1'b1;
    cyc();
    cyc();
    rst = 1'b1;
    icp = 1'b0;
    rd_d(8'h81, 8'h00, "rst_bus_zero");
    rst = 1'b0;
    chk_int(3, 1'b0, "rst_icf_int");
    chk_int(2, 1'b0, "rst_tov_int");
    idle(6);
    rd_i(6'h16, 8'h00, "rst_no_capture");
    rd_d(8'h81, 8'h00, "rst_tccr");
    chk_int(3, 1'b0, "rst_icf_int_late");

    idle(2);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover: got %0d pending entries expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/atmega_tim_icp.md
# atmega_tim_icp

16-bit input-capture timer: the receive side of the PWM/compare outputs produced by the 8-bit timers. It samples an external pin `icp` and optionally filters it. On the selected edge it snapshots a free-running 16-bit counter into ICR and raises an interrupt flag. It sits on the same IO/data register bus as the other timers and consumes the shared prescaler clocks.

## Interface
- `BUS_ADDR_IO_LEN`, 6, IO-space address width
- `BUS_ADDR_DATA_LEN`, 8, data-space address width
- `TCCR_ADDR`, 'h81, control register (data space)
- `TCNTL_ADDR` / `TCNTH_ADDR`, 'h84 / 'h85, counter low/high (data space)
- `ICRL_ADDR` / `ICRH_ADDR`, 'h86 / 'h87, capture low/high, read-only (data space)
- `TIMSK_ADDR`, 'h6F, interrupt mask (data space)
- `TIFR_ADDR`, 'h16, flag register (IO space; data-space alias is +'h20)
- Clocking and reset: one clock; reset is synchronous and active-high.
- `rst` in 1: synchronous active-high reset
- `clk` in 1: core clock
- `clk8`, `clk64`, `clk256`, `clk1024` in 1 each: prescaler clocks, synchronous to `clk`
- `addr_io` in BUS_ADDR_IO_LEN; `wr_io`, `rd_io` in 1; `bus_io_in` in 8; `bus_io_out` out 8
- `addr_dat` in BUS_ADDR_DATA_LEN; `wr_dat`, `rd_dat` in 1; `bus_dat_in` in 8; `bus_dat_out` out 8
- `icp` in 1: asynchronous capture pin
- `tov_int` out 1: overflow interrupt request
- `tov_int_rst` in 1: overflow vector acknowledge
- `icf_int` out 1: capture interrupt request
- `icf_int_rst` in 1: capture vector acknowledge

## Operation
- TCCR bit assignments:
  - [2:0] CS clock select: 0 stop, 1 clk, 2 clk8, 3 clk64, 4 clk256, 5 clk1024, 6/7 stop.
  - [6] ICES: 1 captures on the rising edge, 0 on the falling edge.
  - [7] ICNC: noise canceller enable.
  - Bits 5:3 read back as written and have no function.
- Count tick:
  - CS=1: every `clk`.
  - CS=2..5: on a rising edge of the selected prescaler clock, detected against a registered copy of that clock.
- TCNT increments by 1 per tick and wraps 'hFFFF→'h0000. The wrap sets TIFR[0] (TOV).
- Capture path: `icp` → 2-flop synchronizer → optional canceller → filtered level → edge detect against a delayed copy → ICES polarity check → capture.
  - Canceller: the filtered level changes only after 4 consecutive equal synchronized samples taken every `clk`.
- On capture:
  - ICR ← TCNT value as registered at that edge (pre-increment).
  - TIFR[5] (ICF) ← 1.
  - If ICF is already set, ICR is still overwritten.
- Capture is independent of CS: it also occurs with the counter stopped.
- Changing ICES or ICNC never produces a capture by itself; only a change of the filtered level does.
- 16-bit access uses a shared 8-bit TEMP register:
  - Read TCNTL/ICRL: returns the low byte and latches the high byte into TEMP at that edge.
  - Read TCNTH/ICRH: returns TEMP.
  - Write TCNTH: loads TEMP.
  - Write TCNTL: loads TCNT ← {TEMP, data}.
  - Writes to ICRL/ICRH are ignored.
- TIFR: bit 0 TOV, bit 5 ICF; other bits read 0. Writing 1 clears a bit; writing 0 leaves it unchanged.
- Flag clearing: `tov_int_rst` clears TOV and `icf_int_rst` clears ICF.
- TIMSK: bit 0 TOIE, bit 5 ICIE.
- Interrupt outputs: `tov_int` = TOV & TOIE; `icf_int` = ICF & ICIE.
- Register reads: combinational, qualified by `rd_io`/`rd_dat`; outputs are 'h00 when not addressed or in reset.

## Timing
- Reset values:
  - All registers, TEMP, synchronizer and filter state = 0.
  - Filtered level and its delayed copy = 0.
  - `tov_int` = `icf_int` = 0; bus outputs = 'h00.
- Capture latency, from the first `clk` edge that samples the new `icp` level to the edge that updates ICR/ICF:
  - ICNC=0: 3 cycles.
  - ICNC=1: 6 cycles.
  - `icf_int` follows combinationally from ICF.
- Minimum pulse width: a pulse shorter than 4 cycles with ICNC=1 produces no capture.
- Same-cycle conflicts:
  - Hardware flag set beats a software or acknowledge clear in the same cycle.
  - A TCNTL write beats that cycle's increment and any overflow.
  - A register read during a capture cycle returns the pre-capture value.
- Overflow: TOV is set on the tick taking 'hFFFF→'h0000; TCNT reads 'h0000 on the following cycle.
- `rst` asserted mid-capture discards any pending edge in the synchronizer and filter.

## Structure
- Shared package holds:
  - Address defaults.
  - Bit positions: CS, ICES, ICNC, TOV, ICF, TOIE, ICIE.
  - CS encodings, identical to those used by the 8-bit timer.
- Sub-module `atmega_icp_filter` contains the synchronizer, 4-sample canceller and edge detector.
  - Inputs: `clk`, `rst`, `icp`, `icnc`, `ices`.
  - Output: one-cycle `capture` strobe.
- Top level contains the prescaler select and edge detect, the counter, the register file, TEMP logic and the flags.

## Test plan
- CS=1, ICES=1, ICNC=0, TCNT preset 'h1234, `icp` 0→1 → ICR = 'h1237 after 3 cycles, ICF=1; `icf_int`=1 only with ICIE=1.
- ICNC=1, 3-cycle high glitch → no capture; 4-cycle high pulse → one capture 6 cycles after the rise; ICES=0 → capture on the fall instead.
- TCNT preset 'hFFFE, CS=1 → TOV set 2 ticks later; TIFR write 'h01 clears it; clear and overflow in the same cycle → TOV stays 1.
- 16-bit access: write TCNTH='hAB, then TCNTL='hCD → TCNT='hABCD. Read ICRL → low byte; a capture before reading ICRH still returns the latched high byte.
- CS=3 → TCNT advances exactly once per `clk64` rising edge; CS=0 → TCNT frozen while captures still occur.
- `rst` asserted 1 cycle after an `icp` edge → no capture; all outputs 0.
